// File: rtl/cpu_dma_bus_sequencer_if.sv
// Bus ownership handshake between the CPU BIU, the DMA engine and the sequencer.
// The sequencer takes the master modport; the CPU/DMA side takes the slave modport.
interface cpu_dma_bus_sequencer_if;
  logic       cpu_req;
  logic       cpu_hold_ack;
  logic       dma_req;
  logic       cpu_grant;
  logic       dma_grant;
  logic       cpu_hold_req;
  logic       bus_busy;
  logic [1:0] owner;

  modport master (
    input  cpu_req, cpu_hold_ack, dma_req,
    output cpu_grant, dma_grant, cpu_hold_req, bus_busy, owner
  );

  modport slave (
    output cpu_req, cpu_hold_ack, dma_req,
    input  cpu_grant, dma_grant, cpu_hold_req, bus_busy, owner
  );
endinterface

// File: rtl/cpu_dma_bus_sequencer.sv
// Registered CPU/DMA bus ownership controller: HOLD/HLDA takeover from the CPU,
// fixed turnaround between owners, and a DMA burst bound so the CPU is never starved.
module cpu_dma_bus_sequencer #(
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned CPU_MIN     = 4,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  cpu_dma_bus_sequencer_if.master         bus
);

  localparam int unsigned CW = $clog2(CPU_MIN + 1);
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] CPU_MIN_V  = CW'(CPU_MIN);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CPU      = 3'd1,
    S_CPU_HOLD = 3'd2,
    S_TURN     = 3'd3,
    S_DMA      = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cpu_cnt;
  logic [TW-1:0] turn_cnt;
  logic [BW-1:0] burst_cnt;
  logic          starve;

  logic cpu_min_met;
  logic turn_last;
  logic burst_last;

  assign cpu_min_met = (cpu_cnt >= CPU_MIN_V);
  assign turn_last   = (turn_cnt == TURN_LAST);
  assign burst_last  = (burst_cnt == BURST_LAST);

  // Next owner selection; a forced DMA exit hands the bus to a waiting CPU first.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.dma_req)      state_nxt = S_DMA;
        else if (bus.cpu_req) state_nxt = S_CPU;
      end
      S_CPU: begin
        if (!bus.cpu_req)                     state_nxt = S_TURN;
        else if (bus.dma_req && cpu_min_met)  state_nxt = S_CPU_HOLD;
      end
      S_CPU_HOLD: begin
        if (bus.cpu_hold_ack || !bus.cpu_req) state_nxt = S_TURN;
      end
      S_TURN: begin
        if (turn_last) begin
          if (starve && bus.cpu_req) state_nxt = S_CPU;
          else if (bus.dma_req)      state_nxt = S_DMA;
          else if (bus.cpu_req)      state_nxt = S_CPU;
          else                       state_nxt = S_IDLE;
        end
      end
      S_DMA: begin
        if (!bus.dma_req || (bus.cpu_req && burst_last)) state_nxt = S_TURN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and output decodes of the next state, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cpu_cnt          <= '0;
      turn_cnt         <= '0;
      burst_cnt        <= '0;
      starve           <= 1'b0;
      bus.cpu_grant    <= 1'b0;
      bus.dma_grant    <= 1'b0;
      bus.cpu_hold_req <= 1'b0;
      bus.bus_busy     <= 1'b0;
      bus.owner        <= 2'b00;
    end else begin
      state            <= state_nxt;
      bus.cpu_grant    <= (state_nxt == S_CPU) || (state_nxt == S_CPU_HOLD);
      bus.dma_grant    <= (state_nxt == S_DMA);
      bus.cpu_hold_req <= (state_nxt == S_CPU_HOLD);
      bus.bus_busy     <= (state_nxt != S_IDLE);
      if ((state_nxt == S_CPU) || (state_nxt == S_CPU_HOLD)) bus.owner <= 2'b01;
      else if (state_nxt == S_DMA)                          bus.owner <= 2'b10;
      else                                                  bus.owner <= 2'b00;

      // Counters hold zero outside their own state, so every entry starts fresh.
      if (state != S_CPU)              cpu_cnt <= '0;
      else if (cpu_cnt != CPU_MIN_V)   cpu_cnt <= cpu_cnt + CW'(1);

      if (state != S_TURN)             turn_cnt <= '0;
      else if (!turn_last)             turn_cnt <= turn_cnt + TW'(1);

      if (state != S_DMA)              burst_cnt <= '0;
      else if (!burst_last)            burst_cnt <= burst_cnt + BW'(1);

      if (state == S_DMA && state_nxt == S_TURN && bus.dma_req)
        starve <= 1'b1;
      else if (state != S_CPU && state_nxt == S_CPU)
        starve <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_dma_bus_sequencer.sv
// Directed bench for cpu_dma_bus_sequencer: an ownership-level reference model
// checked every cycle, plus literal expectations pinning the key timings.
module tb_cpu_dma_bus_sequencer;

  localparam int MAX_BURST   = 16;
  localparam int CPU_MIN     = 4;
  localparam int TURN_CYCLES = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_dma_bus_sequencer_if bus();

  cpu_dma_bus_sequencer #(
    .MAX_BURST  (MAX_BURST),
    .CPU_MIN    (CPU_MIN),
    .TURN_CYCLES(TURN_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who holds the bus, whether HOLD is out, and how long each phase has run.
  int m_own;        // 0 nobody, 1 CPU, 2 DMA
  bit m_hold;
  bit m_busy;
  bit m_starve;
  int m_cpu_age;
  int m_dma_age;
  int m_turn_left;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_hold = 1'b0; m_busy = 1'b0; m_starve = 1'b0;
    m_cpu_age = 0; m_dma_age = 0; m_turn_left = 0;
  endtask

  task automatic start_turn();
    m_own = 0; m_hold = 1'b0; m_turn_left = TURN_CYCLES;
  endtask

  task automatic give(input int who);
    m_busy = 1'b1; m_own = who; m_hold = 1'b0;
    if (who == 1) begin m_cpu_age = 0; m_starve = 1'b0; end
    else m_dma_age = 0;
  endtask

  task automatic model_step(input bit c, input bit a, input bit d);
    int served;
    if (!m_busy) begin
      if (d) give(2);
      else if (c) give(1);
    end else if (m_own == 1 && !m_hold) begin
      served = m_cpu_age;
      m_cpu_age++;
      if (!c) start_turn();
      else if (d && served >= CPU_MIN) m_hold = 1'b1;
    end else if (m_own == 1) begin
      if (a || !c) start_turn();
    end else if (m_own == 2) begin
      served = m_dma_age;
      m_dma_age++;
      if (!d) start_turn();
      else if (c && served >= MAX_BURST - 1) begin start_turn(); m_starve = 1'b1; end
    end else begin
      m_turn_left--;
      if (m_turn_left == 0) begin
        if (m_starve && c) give(1);
        else if (d) give(2);
        else if (c) give(1);
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("cpu_grant",    int'(bus.cpu_grant),    (m_own == 1) ? 1 : 0);
    chk("dma_grant",    int'(bus.dma_grant),    (m_own == 2) ? 1 : 0);
    chk("cpu_hold_req", int'(bus.cpu_hold_req), int'(m_hold));
    chk("bus_busy",     int'(bus.bus_busy),     int'(m_busy));
    chk("owner",        int'(bus.owner),        m_own);
    chk("grant_overlap", int'(bus.cpu_grant & bus.dma_grant), 0);
  endtask

  // One clock: drive inputs at the falling edge, step the model at the rising edge, check at the next falling edge.
  task automatic cycle(input bit c, input bit a, input bit d);
    bus.cpu_req = c; bus.cpu_hold_ack = a; bus.dma_req = d;
    @(posedge clk);
    if (rst_n) model_step(c, a, d);
    @(negedge clk);
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_hold_ack = 1'b0; bus.dma_req = 1'b0;
    model_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("idle_busy", int'(bus.bus_busy), 0);

    // Simultaneous request: DMA wins, then one turnaround, then CPU.
    cycle(1'b1, 1'b0, 1'b1);
    chk("sim_dma_grant", int'(bus.dma_grant), 1);
    chk("sim_cpu_grant", int'(bus.cpu_grant), 0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("sim_turn_owner", int'(bus.owner), 0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("sim_cpu_grant2", int'(bus.cpu_grant), 1);
    chk("sim_cpu_owner", int'(bus.owner), 1);

    // CPU minimum window: dma_req from CPU cycle 1, HOLD after cycle 4, ack at cycle 7.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    chk("win_no_hold_yet", int'(bus.cpu_hold_req), 0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("win_hold_up", int'(bus.cpu_hold_req), 1);
    chk("win_cpu_kept", int'(bus.cpu_grant), 1);
    repeat (2) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    chk("win_turn_owner", int'(bus.owner), 0);
    chk("win_turn_hold", int'(bus.cpu_hold_req), 0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("win_dma_grant", int'(bus.dma_grant), 1);

    // Burst limit with cpu_req pending: exactly MAX_BURST DMA cycles, then CPU.
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (!bus.dma_grant) break;
      n++;
    end
    chk("burst_len", n, 16);
    chk("burst_turn_owner", int'(bus.owner), 0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("starve_cpu_grant", int'(bus.cpu_grant), 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      n++;
      if (bus.cpu_hold_req) break;
    end
    chk("rehold_cycles", n, 5);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("unb_dma_grant", int'(bus.dma_grant), 1);

    // Unbounded DMA with cpu_req low; a late cpu_req forces exit on the next edge.
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (bus.dma_grant) n++;
    end
    chk("unb_dma_cycles", n, 100);
    cycle(1'b1, 1'b0, 1'b1);
    chk("forced_release", int'(bus.dma_grant), 0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("forced_cpu_grant", int'(bus.cpu_grant), 1);

    // HOLD stays out after dma_req drops; ack with cpu_req high returns to CPU.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (bus.cpu_hold_req) break;
    end
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    chk("hold_sticky", int'(bus.cpu_hold_req), 1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("hold_ack_turn", int'(bus.owner), 0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("hold_back_to_cpu", int'(bus.cpu_grant), 1);

    // Same, but cpu_req drops during the turnaround so the bus goes idle.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (bus.cpu_hold_req) break;
    end
    cycle(1'b1, 1'b0, 1'b0);
    chk("hold_sticky2", int'(bus.cpu_hold_req), 1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("hold_to_idle", int'(bus.bus_busy), 0);

    // Asynchronous reset while DMA owns the bus.
    cycle(1'b0, 1'b0, 1'b1);
    chk("pre_rst_dma", int'(bus.dma_grant), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_dma_grant", int'(bus.dma_grant), 0);
    chk("rst_owner", int'(bus.owner), 0);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("post_rst_busy", int'(bus.bus_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
